regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Round-robin arbiter sharing the single register-file write port between two writeback requesters: the ALU path and the load/memory path. Each requester uses a valid/ready handshake; one transfer is granted per cycle. The granted write is registered and driven onto the register-file write port (RegWrite, write address, write data) one cycle later. Sits between execute/memory writeback sources and the register file.

Parameters:
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 32, register data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
stall_i  input  1  pipeline stall; when high, no grant is issued
alu_valid_i  input  1  ALU requester has a write pending
alu_addr_i  input  ADDR_WIDTH  ALU destination register
alu_data_i  input  DATA_WIDTH  ALU result
alu_ready_o  output  1  ALU request accepted this cycle (combinational)
mem_valid_i  input  1  load requester has a write pending
mem_addr_i  input  ADDR_WIDTH  load destination register
mem_data_i  input  DATA_WIDTH  load data
mem_ready_o  output  1  load request accepted this cycle (combinational)
rf_we_o  output  1  register-file write enable (registered)
rf_waddr_o  output  ADDR_WIDTH  register-file write address (registered)
rf_wdata_o  output  DATA_WIDTH  register-file write data (registered)

Behaviour:
- Reset (async, immediate): rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, last_grant=ALU; ready outputs 0 while rst high.
- Transfer occurs on a rising edge when valid_i && ready_o for a requester. Requester holds addr/data stable while valid and not ready.
- Grant logic (combinational, from current inputs and last_grant):
  - stall_i=1: both ready_o=0.
  - Only one valid: that requester ready=1.
  - Both valid: grant the requester NOT equal to last_grant (MEM wins first conflict after reset).
  - Neither valid: both ready=0.
- State last_grant ∈ {ALU, MEM}: updated only on a transfer, to the granted source; unchanged on idle/stall cycles.
- Output register, latency 1: at edge of a transfer, rf_waddr_o/rf_wdata_o load the granted addr/data; rf_we_o=1 unless granted addr==0, in which case rf_we_o=0 (x0 write accepted and discarded; addr/data still loaded).
- No transfer on an edge: rf_we_o=0; rf_waddr_o/rf_wdata_o hold previous values.
- Throughput: one write per cycle sustained; under continuous dual requests grants strictly alternate.
- Same destination register from both sources in one cycle: no merging; granted one written first, other in a later cycle.
- Reset asserted mid-operation: pending (unaccepted) requests are not retained; outputs and last_grant return to reset values immediately.

Optional Feature:
RF_WB_STATS_EN: adds output conflict_cnt_o [15:0], reset 0, incremented on every edge where both valid_i are high and stall_i=0; saturates at 16'hFFFF; cleared by rst. Without the macro the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with alu_valid_i=1 -> rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, both ready=0 immediately.
- Single ALU write: alu_valid_i=1, addr=5, data=32'hDEADBEEF, one cycle -> alu_ready_o=1 same cycle; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=32'hDEADBEEF; following cycle rf_we_o=0.
- Conflict after reset: both valid (alu addr=3/data=1, mem addr=4/data=2) held 4 cycles -> grants MEM, ALU, MEM, ALU; rf_waddr_o sequence 4,3,4,3 with rf_we_o=1 each cycle.
- Stall: both valid with stall_i=1 for 3 cycles -> ready=0, rf_we_o=0, last_grant unchanged; on release, grant follows pre-stall round-robin order.
- x0 write: mem_valid_i=1, addr=0, data=32'h1234 -> mem_ready_o=1; next cycle rf_we_o=0, rf_wdata_o=32'h1234.
- With RF_WB_STATS_EN: 10 conflict cycles then 2 single-request cycles -> conflict_cnt_o=10; force to 16'hFFFF then one conflict -> remains 16'hFFFF.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_wb_arbiter: round-robin arbiter for the ALU / load writeback paths  |
// | onto the single register-file write port. Optional macro: RF_WB_STATS_EN.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_addr_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  output logic                  alu_ready_o,
  input  logic                  mem_valid_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  mem_ready_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o
`ifdef RF_WB_STATS_EN
  ,
  output logic [15:0]           conflict_cnt_o
`endif
);

  localparam logic [0:0] c_GNT_ALU = 1'b0;
  localparam logic [0:0] c_GNT_MEM = 1'b1;

  logic [0:0]            r_last_grant;
  logic                  w_alu_xfer;
  logic                  w_mem_xfer;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_data;

  // On a conflict the source that did not win last time gets the port.
  always_comb begin
    alu_ready_o = 1'b0;
    mem_ready_o = 1'b0;
    if (!rst && !stall_i) begin
      if (alu_valid_i && mem_valid_i) begin
        if (r_last_grant == c_GNT_ALU) mem_ready_o = 1'b1;
        else                           alu_ready_o = 1'b1;
      end else begin
        alu_ready_o = alu_valid_i;
        mem_ready_o = mem_valid_i;
      end
    end
  end

  assign w_alu_xfer = alu_valid_i & alu_ready_o;
  assign w_mem_xfer = mem_valid_i & mem_ready_o;
  assign w_gnt_addr = w_mem_xfer ? mem_addr_i : alu_addr_i;
  assign w_gnt_data = w_mem_xfer ? mem_data_i : alu_data_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= c_GNT_ALU;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
    end else if (w_alu_xfer || w_mem_xfer) begin
      r_last_grant <= w_mem_xfer ? c_GNT_MEM : c_GNT_ALU;
      // Writes to x0 are accepted and consumed but never reach the file.
      rf_we_o      <= (w_gnt_addr != '0);
      rf_waddr_o   <= w_gnt_addr;
      rf_wdata_o   <= w_gnt_data;
    end else begin
      rf_we_o      <= 1'b0;
    end
  end

`ifdef RF_WB_STATS_EN
  logic w_conflict;
  assign w_conflict = alu_valid_i & mem_valid_i & ~stall_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      conflict_cnt_o <= '0;
    else if (w_conflict && conflict_cnt_o != '1)  conflict_cnt_o <= conflict_cnt_o + 16'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter: directed and randomized checks of regfile_wb_arbiter |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        alu_valid_i, mem_valid_i;
  logic [4:0]  alu_addr_i, mem_addr_i;
  logic [31:0] alu_data_i, mem_data_i;
  logic        alu_ready_o, mem_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
`ifdef RF_WB_STATS_EN
  logic [15:0] conflict_cnt_o;
  int          m_conflicts;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state: who won last, and what the write port should show.
  string       m_last;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .alu_valid_i (alu_valid_i),
    .alu_addr_i  (alu_addr_i),
    .alu_data_i  (alu_data_i),
    .alu_ready_o (alu_ready_o),
    .mem_valid_i (mem_valid_i),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_ready_o (mem_ready_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o)
`ifdef RF_WB_STATS_EN
    ,
    .conflict_cnt_o (conflict_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = "ALU";
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
`ifdef RF_WB_STATS_EN
    m_conflicts = 0;
`endif
  endtask

  // One clock cycle, entered and left at a falling edge. Returns the winner.
  task automatic cycle(input bit st, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       output string winner);
    stall_i = st;
    alu_valid_i = av; alu_addr_i = aa; alu_data_i = ad;
    mem_valid_i = mv; mem_addr_i = ma; mem_data_i = md;
    if (st || (!av && !mv)) winner = "NONE";
    else if (av && mv)      winner = (m_last == "ALU") ? "MEM" : "ALU";
    else                    winner = av ? "ALU" : "MEM";
    #1;
    check("alu_ready", alu_ready_o, (winner == "ALU") ? 1 : 0);
    check("mem_ready", mem_ready_o, (winner == "MEM") ? 1 : 0);
    @(posedge clk);
`ifdef RF_WB_STATS_EN
    if (av && mv && !st && m_conflicts < 65535) m_conflicts++;
`endif
    if (winner == "NONE") begin
      m_we = 1'b0;
    end else begin
      m_last  = winner;
      m_waddr = (winner == "ALU") ? aa : ma;
      m_wdata = (winner == "ALU") ? ad : md;
      m_we    = (m_waddr != 0);
    end
    #1;
    check("rf_we", rf_we_o, m_we);
    check("rf_waddr", rf_waddr_o, m_waddr);
    check("rf_wdata", rf_wdata_o, m_wdata);
`ifdef RF_WB_STATS_EN
    check("conflict_cnt", conflict_cnt_o, m_conflicts);
`endif
    @(negedge clk);
  endtask

  initial begin
    string w;
    bit          av, mv, st;
    logic [4:0]  aa, ma;
    logic [31:0] ad, md;

    rst = 1'b1; stall_i = 0;
    alu_valid_i = 0; alu_addr_i = 0; alu_data_i = 0;
    mem_valid_i = 0; mem_addr_i = 0; mem_data_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_we", rf_we_o, 0);
    check("reset_waddr", rf_waddr_o, 0);
    check("reset_wdata", rf_wdata_o, 0);
    @(negedge clk);

    // Single ALU write, then idle.
    cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, w);
    cycle(0, 0, 0, 0, 0, 0, 0, w);

    // Conflict after reset: MEM, ALU, MEM, ALU.
    repeat (4) cycle(0, 1, 5'd3, 32'd1, 1, 5'd4, 32'd2, w);

    // Stall holds arbitration state; the release grant keeps the rotation.
    repeat (3) cycle(1, 1, 5'd3, 32'd1, 1, 5'd4, 32'd2, w);
    cycle(0, 1, 5'd3, 32'd1, 1, 5'd4, 32'd2, w);
    check("post_stall_waddr", rf_waddr_o, 5'd4);

    // Write to x0 is consumed but not enabled.
    cycle(0, 0, 0, 0, 1, 5'd0, 32'h1234, w);
    check("x0_wdata", rf_wdata_o, 32'h1234);
    check("x0_we", rf_we_o, 0);

    // Asynchronous reset in the middle of a cycle with a request pending.
    cycle(0, 1, 5'd9, 32'hCAFE, 0, 0, 0, w);
    alu_valid_i = 1; alu_addr_i = 5'd7; alu_data_i = 32'h77;
    rst = 1'b1;
    #1;
    check("midrst_we", rf_we_o, 0);
    check("midrst_waddr", rf_waddr_o, 0);
    check("midrst_wdata", rf_wdata_o, 0);
    check("midrst_alu_ready", alu_ready_o, 0);
    check("midrst_mem_ready", mem_ready_o, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    // Fresh conflict after reset must go to MEM again.
    cycle(0, 1, 5'd3, 32'd1, 1, 5'd4, 32'd2, w);
    check("post_rst_conflict_waddr", rf_waddr_o, 5'd4);

    // Randomized traffic; an unaccepted request keeps its payload.
    av = 0; mv = 0; aa = 0; ma = 0; ad = 0; md = 0;
    for (int i = 0; i < 400; i++) begin
      if (!av) begin
        av = ($urandom_range(0, 3) != 0);
        aa = 5'($urandom); ad = $urandom;
      end
      if (!mv) begin
        mv = ($urandom_range(0, 3) != 0);
        ma = 5'($urandom); md = $urandom;
      end
      st = ($urandom_range(0, 7) == 0);
      cycle(st, av, aa, ad, mv, ma, md, w);
      if (w == "ALU") av = 0;
      if (w == "MEM") mv = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
